// File: rtl/vscale_ext_int_ctrl.sv
// External interrupt controller in front of the CSR file: synchronizes raw sources,
// gates them through level/edge gateways and exposes claim/complete over a small register bus.
module vscale_ext_int_ctrl #(
  parameter int N_SRC = 8,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  output logic [N_SRC-1:0] ext_interrupts,
  input  logic             bus_valid,
  input  logic [3:0]       bus_addr,
  input  logic             bus_wen,
  input  logic [XLEN-1:0]  bus_wdata,
  output logic [XLEN-1:0]  bus_rdata,
  output logic             bus_rvalid
);

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_EDGE    = 2'd2;
  localparam logic [1:0] REG_CLAIM   = 2'd3;

  logic [N_SRC-1:0] sync1_reg;
  logic [N_SRC-1:0] sync2_reg;
  logic [N_SRC-1:0] sync3_reg;
  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] enable_reg;
  logic [N_SRC-1:0] edge_mode_reg;
  logic [N_SRC-1:0] in_service_reg;
  logic [N_SRC-1:0] in_service_next;
  logic [XLEN-1:0]  bus_rdata_reg;
  logic             bus_rvalid_reg;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] gw_set;
  logic [N_SRC-1:0] claim_onehot;
  logic [N_SRC-1:0] claim_clr;
  logic [N_SRC-1:0] comp_hit;
  logic [N_SRC-1:0] ext_int;
  logic [XLEN-1:0]  claim_id;
  logic [XLEN-1:0]  rd_mux;

  logic [1:0] reg_sel;
  logic       rd_acc;
  logic       wr_acc;
  logic       claim_rd;
  logic       comp_wr;
  logic       unused_addr_bits;

  assign reg_sel          = bus_addr[3:2];
  assign unused_addr_bits = ^bus_addr[1:0];
  assign rd_acc           = bus_valid & ~bus_wen;
  assign wr_acc           = bus_valid & bus_wen;
  assign claim_rd         = rd_acc && (reg_sel == REG_CLAIM);
  assign comp_wr          = wr_acc && (reg_sel == REG_CLAIM);
  assign claim_clr        = claim_rd ? claim_onehot : '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign rise[gi]    = sync2_reg[gi] & ~sync3_reg[gi];
      // Level sources are held off while in service so the handler is not re-signalled.
      assign gw_set[gi]  = edge_mode_reg[gi] ? rise[gi] : (sync2_reg[gi] & ~in_service_reg[gi]);
      assign comp_hit[gi] = comp_wr && (bus_wdata == XLEN'(gi + 1)) && in_service_reg[gi];
      // A set in the same cycle as the claim clear wins.
      assign pending_next[gi]    = gw_set[gi] | (pending_reg[gi] & ~claim_clr[gi]);
      assign in_service_next[gi] = (in_service_reg[gi] | claim_clr[gi]) & ~comp_hit[gi];
      assign ext_int[gi] = pending_reg[gi] & enable_reg[gi] & ~in_service_reg[gi];
    end
  endgenerate

  // Lowest-numbered active source wins; scan downward so the last hit is the lowest.
  always_comb begin
    claim_id     = '0;
    claim_onehot = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (ext_int[i]) begin
        claim_id        = XLEN'(i + 1);
        claim_onehot    = '0;
        claim_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_PENDING: rd_mux = XLEN'(pending_reg);
      REG_ENABLE:  rd_mux = XLEN'(enable_reg);
      REG_EDGE:    rd_mux = XLEN'(edge_mode_reg);
      REG_CLAIM:   rd_mux = claim_id;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      sync3_reg      <= '0;
      pending_reg    <= '0;
      enable_reg     <= '0;
      edge_mode_reg  <= '0;
      in_service_reg <= '0;
      bus_rdata_reg  <= '0;
      bus_rvalid_reg <= 1'b0;
    end else begin
      sync1_reg      <= irq_src;
      sync2_reg      <= sync1_reg;
      sync3_reg      <= sync2_reg;
      pending_reg    <= pending_next;
      in_service_reg <= in_service_next;
      if (wr_acc && (reg_sel == REG_ENABLE)) begin
        enable_reg <= bus_wdata[N_SRC-1:0];
      end
      if (wr_acc && (reg_sel == REG_EDGE)) begin
        edge_mode_reg <= bus_wdata[N_SRC-1:0];
      end
      bus_rvalid_reg <= rd_acc;
      if (rd_acc) begin
        bus_rdata_reg <= rd_mux;
      end
    end
  end

  assign ext_interrupts = ext_int;
  assign bus_rdata      = bus_rdata_reg;
  assign bus_rvalid     = bus_rvalid_reg;

endmodule

// File: tb/tb_vscale_ext_int_ctrl.sv
// Directed bench for vscale_ext_int_ctrl: read results go through a scoreboard queue,
// interrupt outputs are checked directly after each step.
module tb_vscale_ext_int_ctrl;

  localparam int N_SRC = 8;
  localparam int XLEN  = 32;
  localparam logic [3:0] A_PEND  = 4'h0;
  localparam logic [3:0] A_EN    = 4'h4;
  localparam logic [3:0] A_EDGE  = 4'h8;
  localparam logic [3:0] A_CLAIM = 4'hC;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_SRC-1:0] irq_src;
  logic [N_SRC-1:0] ext_interrupts;
  logic             bus_valid;
  logic [3:0]       bus_addr;
  logic             bus_wen;
  logic [XLEN-1:0]  bus_wdata;
  logic [XLEN-1:0]  bus_rdata;
  logic             bus_rvalid;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  vscale_ext_int_ctrl #(.N_SRC(N_SRC), .XLEN(XLEN)) dut (
    .clk(clk),
    .reset(reset),
    .irq_src(irq_src),
    .ext_interrupts(ext_interrupts),
    .bus_valid(bus_valid),
    .bus_addr(bus_addr),
    .bus_wen(bus_wen),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_ext(input string tag, input logic [7:0] exp);
    chk(tag, 32'(ext_interrupts), 32'(exp));
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    bus_valid = 1'b1;
    bus_wen   = 1'b0;
    bus_addr  = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    bus_valid = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus_rvalid), 32'd1);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input string tag);
    bus_valid = 1'b1;
    bus_wen   = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    tick();
    bus_valid = 1'b0;
    bus_wen   = 1'b0;
    chk({tag, "_no_rvalid"}, 32'(bus_rvalid), 32'd0);
  endtask

  // Read-data monitor: every rvalid pops one expected value.
  initial begin : mon
    logic [31:0] e;
    string       t;
    forever begin
      @(posedge clk);
      #2;
      if (bus_rvalid === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL rvalid_unexpected: observed=rvalid expected=no_read_outstanding");
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          chk(t, bus_rdata, e);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    irq_src   = '0;
    bus_valid = 1'b0;
    bus_wen   = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    idle(3);
    chk_ext("reset_ext", 8'h00);
    chk("reset_rvalid", 32'(bus_rvalid), 32'd0);
    chk("reset_rdata", bus_rdata, 32'd0);
    reset = 1'b0;

    // Level source 0: latency, claim, complete with source still high
    bus_write(A_EN, 32'h01, "t1_en");
    irq_src = 8'h01;
    tick();
    chk_ext("t1_lat_e1", 8'h00);
    tick();
    chk_ext("t1_lat_e2", 8'h00);
    tick();
    chk_ext("t1_lat_e3", 8'h01);
    irq_src = 8'h00;
    idle(3);
    bus_read(A_CLAIM, 32'd1, "t1_claim");
    chk_ext("t1_in_service", 8'h00);
    bus_read(A_PEND, 32'h00, "t1_pend_after_claim");
    irq_src = 8'h01;
    idle(3);
    chk_ext("t1_held_off", 8'h00);
    bus_read(A_PEND, 32'h00, "t1_pend_held_off");
    bus_write(A_CLAIM, 32'd1, "t1_complete");
    chk_ext("t1_complete_e0", 8'h00);
    tick();
    chk_ext("t1_repend", 8'h01);
    irq_src = 8'h00;
    idle(3);
    bus_read(A_CLAIM, 32'd1, "t1_claim2");
    bus_write(A_CLAIM, 32'd1, "t1_complete2");
    chk_ext("t1_clean", 8'h00);

    // Priority among level sources 2 and 7
    bus_write(A_EN, 32'hFFFF_FFFF, "t2_en");
    bus_read(A_EN, 32'h0000_00FF, "t2_en_readback");
    irq_src = 8'h84;
    idle(3);
    irq_src = 8'h00;
    idle(3);
    chk_ext("t2_ext", 8'h84);
    bus_read(A_CLAIM, 32'd3, "t2_claim_a");
    bus_read(A_CLAIM, 32'd8, "t2_claim_b");
    bus_read(A_CLAIM, 32'd0, "t2_claim_none");
    bus_read(A_PEND, 32'h00, "t2_pend");
    chk_ext("t2_ext_after", 8'h00);
    bus_write(A_CLAIM, 32'd3, "t2_complete3");
    bus_write(A_CLAIM, 32'd8, "t2_complete8");

    // Edge source 1: second edge pends while in service
    bus_write(A_EDGE, 32'h02, "t3_edge");
    bus_write(A_EN, 32'h02, "t3_en");
    bus_read(A_EDGE, 32'h02, "t3_edge_readback");
    irq_src = 8'h02;
    idle(3);
    chk_ext("t3_first_edge", 8'h02);
    irq_src = 8'h00;
    idle(3);
    bus_read(A_CLAIM, 32'd2, "t3_claim");
    chk_ext("t3_in_service", 8'h00);
    irq_src = 8'h02;
    idle(3);
    irq_src = 8'h00;
    idle(3);
    chk_ext("t3_second_edge_hidden", 8'h00);
    bus_read(A_PEND, 32'h02, "t3_pend");
    bus_write(A_CLAIM, 32'd2, "t3_complete");
    chk_ext("t3_after_complete", 8'h02);
    bus_read(A_CLAIM, 32'd2, "t3_claim2");
    bus_write(A_CLAIM, 32'd2, "t3_complete2");
    chk_ext("t3_clean", 8'h00);

    // Masking: pending but disabled source 5
    bus_write(A_EN, 32'h00, "t4_en0");
    bus_write(A_EDGE, 32'h00, "t4_edge0");
    irq_src = 8'h20;
    idle(3);
    bus_read(A_PEND, 32'h20, "t4_pend");
    chk_ext("t4_masked", 8'h00);
    bus_read(A_CLAIM, 32'd0, "t4_claim_masked");
    bus_write(A_EN, 32'h20, "t4_en");
    chk_ext("t4_unmasked", 8'h20);
    irq_src = 8'h00;
    idle(3);
    bus_read(A_CLAIM, 32'd6, "t4_claim");
    bus_write(A_CLAIM, 32'd6, "t4_complete");
    chk_ext("t4_clean", 8'h00);

    // Illegal completes: source 0 in service with a hidden re-pend
    bus_write(A_EDGE, 32'h01, "t5_edge");
    bus_write(A_EN, 32'h03, "t5_en");
    irq_src = 8'h03;
    idle(3);
    irq_src = 8'h00;
    idle(3);
    chk_ext("t5_ext", 8'h03);
    bus_read(A_CLAIM, 32'd1, "t5_claim1");
    irq_src = 8'h01;
    idle(3);
    irq_src = 8'h00;
    idle(3);
    chk_ext("t5_hidden", 8'h02);
    bus_write(A_CLAIM, 32'd0, "t5_cmp0");
    chk_ext("t5_after_cmp0", 8'h02);
    bus_write(A_CLAIM, 32'd9, "t5_cmp9");
    chk_ext("t5_after_cmp9", 8'h02);
    bus_write(A_CLAIM, 32'd2, "t5_cmp_not_in_service");
    chk_ext("t5_after_cmp2", 8'h02);
    bus_write(A_CLAIM, 32'h0000_0101, "t5_cmp_wide");
    chk_ext("t5_after_cmp_wide", 8'h02);
    bus_read(A_PEND, 32'h03, "t5_pend");
    bus_write(A_CLAIM, 32'd1, "t5_cmp1");
    chk_ext("t5_after_cmp1", 8'h03);
    bus_read(A_CLAIM, 32'd1, "t5_claim_a");
    bus_read(A_CLAIM, 32'd2, "t5_claim_b");
    bus_write(A_CLAIM, 32'd1, "t5_fin1");
    bus_write(A_CLAIM, 32'd2, "t5_fin2");
    chk_ext("t5_clean", 8'h00);

    // Rising edge on source 2 in the same cycle as its claim
    bus_write(A_EDGE, 32'h04, "t6_edge");
    bus_write(A_EN, 32'h04, "t6_en");
    irq_src = 8'h04;
    idle(3);
    irq_src = 8'h00;
    idle(3);
    chk_ext("t6_ext", 8'h04);
    irq_src = 8'h04;
    tick();
    tick();
    bus_read(A_CLAIM, 32'd3, "t6_claim_on_edge");
    bus_read(A_PEND, 32'h04, "t6_pend_kept");
    chk_ext("t6_in_service", 8'h00);
    bus_write(A_CLAIM, 32'd3, "t6_complete");
    chk_ext("t6_after_complete", 8'h04);
    irq_src = 8'h00;
    idle(3);
    bus_read(A_CLAIM, 32'd3, "t6_claim2");
    bus_write(A_CLAIM, 32'd3, "t6_complete2");
    chk_ext("t6_clean", 8'h00);

    // Reset right after a claim read
    bus_write(A_EDGE, 32'h00, "t7_edge");
    bus_write(A_EN, 32'h01, "t7_en");
    irq_src = 8'h01;
    idle(3);
    bus_read(A_CLAIM, 32'd1, "t7_claim");
    reset   = 1'b1;
    irq_src = 8'h00;
    tick();
    chk("t7_rvalid", 32'(bus_rvalid), 32'd0);
    chk("t7_rdata", bus_rdata, 32'd0);
    chk_ext("t7_ext", 8'h00);
    reset = 1'b0;
    bus_read(A_PEND, 32'h00, "t7_pend");
    bus_read(A_EN, 32'h00, "t7_en_rd");
    bus_read(A_EDGE, 32'h00, "t7_edge_rd");
    bus_read(A_CLAIM, 32'd0, "t7_claim_rd");
    chk_ext("t7_ext_after", 8'h00);

    idle(3);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d outstanding expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
